// File: rtl/apb_master_bridge.sv
// APB requester: valid/ready command port in, two-phase APB transfer out, one-cycle response pulse.
// Optional wait-state timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic [3:0]                PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [2:0]                PPROT,
    input  logic                      PREADY,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PSLVERR
);
    localparam int PSTRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    if (TIMEOUT_CYCLES < 1 || ADDR_WIDTH < 2 || DATA_WIDTH % 8 != 0) begin : g_bad_cfg
        $error("apb_master_bridge: invalid parameter set");
    end

    logic [1:0]             r_state;
    logic                   r_ready;
    logic [3:0]             r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDR_WIDTH-1:0]  r_paddr;
    logic [DATA_WIDTH-1:0]  r_pwdata;
    logic [PSTRB_WIDTH-1:0] r_pstrb;
    logic [2:0]             r_pprot;
    logic                   r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata;
    logic                   r_rsp_err;
    logic [3:0]             w_sel_dec;

    // Top two address bits pick one of four slaves.
    assign w_sel_dec = 4'b0001 << req_addr[ADDR_WIDTH-1 -: 2];

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_pwrite <= req_write;
                        r_paddr  <= req_addr;
                        r_pprot  <= req_prot;
                        r_psel   <= w_sel_dec;
                        r_ready  <= 1'b0;
                        r_state  <= S_SETUP;
                        // Reads leave PWDATA at its previous value.
                        if (req_write) begin
                            r_pwdata <= req_wdata;
                            r_pstrb  <= req_strb;
                        end else begin
                            r_pstrb  <= '0;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= PSLVERR;
                        r_rsp_rdata <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    // This wait cycle would bring the count to the limit: abort.
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= '0;
                    r_penable <= 1'b0;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PPROT     = r_pprot;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: random requests, a slave model with planned wait states,
// and a monitor checking bus protocol and responses against a transaction-level model.
`timescale 1ns/1ps
module tb_apb_master_bridge;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          PCLK, PRESETn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [3:0]    PSEL;
    logic          PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic          PREADY, PSLVERR;
    logic [DW-1:0] PRDATA;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] pwdata; logic [3:0] strb; logic [2:0] prot; } xfer_t;
    typedef struct { int waits; logic [31:0] rdata; logic err; } plan_t;
    typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;

    plan_t   plan_q[$];
    exp_t    exp_q[$];
    xfer_t   cur;
    logic [31:0] last_wdata;
    int      cyc;
    int      tests, fails;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave: answers the planned transfer with PREADY on ACCESS cycle index 'waits'; garbage elsewhere.
    plan_t sp;
    int    acnt;
    always @(negedge PCLK) begin
        if (PSEL != 4'b0 && !PENABLE) begin
            if (plan_q.size() != 0) sp = plan_q.pop_front();
            else begin sp.waits = 0; sp.rdata = '0; sp.err = 1'b0; end
            acnt    = 0;
            PREADY  = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
        end else if (PSEL != 4'b0 && PENABLE) begin
            if (acnt == sp.waits) begin
                PREADY = 1'b1; PRDATA = sp.rdata; PSLVERR = sp.err;
            end else begin
                PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
            acnt++;
        end else begin
            PREADY  = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
        end
    end

    // Monitor: protocol invariants while selected, plus scoreboard pop on each response pulse.
    logic [3:0] prev_psel = 4'b0;
    exp_t       e;
    always @(negedge PCLK) begin
        if (PRESETn) begin
            check("ready_iff_idle", 128'(req_ready), 128'(PSEL == 4'b0));
            if (PSEL != 4'b0) begin
                check("bus_fields",
                      128'({PADDR, PWDATA, PSTRB, PPROT, PWRITE, PSEL}),
                      128'({cur.addr, cur.pwdata, (cur.wr ? cur.strb : 4'b0), cur.prot, cur.wr,
                            4'(4'b0001 << cur.addr[31:30])}));
                check("penable_phase", 128'(PENABLE), 128'(prev_psel != 4'b0));
            end else begin
                check("penable_idle", 128'(PENABLE), 128'(0));
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data_err", 128'({rsp_rdata, rsp_err}), 128'({e.rdata, e.err}));
                    check("rsp_latency", 128'(cyc), 128'(e.cyc));
                end
            end
            prev_psel = PSEL;
        end
    end

    // Issue one request; called at a negedge, returns at the negedge after acceptance with req_valid still high.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input plan_t p);
        int n;
        int w;
        exp_t x;
        req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb; req_prot = prot;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge PCLK); n++; end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got req_ready=0 for 200 cycles, expected 1");
            return;
        end
        cur.wr = wr; cur.addr = addr; cur.strb = strb; cur.prot = prot;
        cur.pwdata = wr ? wdata : last_wdata;
        if (wr) last_wdata = wdata;
        plan_q.push_back(p);
        w = (TO_EN && p.waits > TMO - 1) ? TMO - 1 : p.waits;
        x.err   = p.err || (TO_EN && p.waits >= TMO);
        x.rdata = (!wr && !x.err) ? p.rdata : 32'h0;
        x.cyc   = cyc + 1 + 2 + w;
        exp_q.push_back(x);
        @(negedge PCLK);
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge PCLK); n++; end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check(nm, 128'({req_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
                        rsp_valid, rsp_rdata, rsp_err}),
                  128'({1'b1, 4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 3'b0, 1'b0, 32'h0, 1'b0}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog");
    end

    plan_t p;
    int    gap;
    initial begin
        tests = 0; fails = 0; last_wdata = '0;
        PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
        repeat (3) @(negedge PCLK);
        check_reset_vals("reset_state");
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Directed cases from the plan.
        p.waits = 0; p.rdata = 32'hDEAD_BEEF; p.err = 1'b0;
        send(1'b0, 32'h4000_0010, 32'h0, 4'hF, 3'd2, p);
        drain();
        p.waits = 2; p.rdata = 32'hAAAA_5555; p.err = 1'b0;
        send(1'b1, 32'hC000_0004, 32'h1234_5678, 4'b0011, 3'd1, p);
        drain();
        p.waits = 0; p.rdata = 32'hFFFF_FFFF; p.err = 1'b1;
        send(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'd0, p);
        drain();
        p.waits = 0; p.rdata = 32'h0; p.err = 1'b0;
        send(1'b1, 32'h8000_0000, 32'h1111_1111, 4'hF, 3'd0, p);
        send(1'b1, 32'h8000_0004, 32'h2222_2222, 4'hC, 3'd0, p);
        drain();
        p.waits = TMO - 1; p.rdata = 32'h0BAD_F00D; p.err = 1'b0;
        send(1'b0, 32'h4000_0020, 32'h0, 4'h0, 3'd3, p);
        p.waits = TMO + 5;
        send(1'b0, 32'h4000_0024, 32'h0, 4'h0, 3'd3, p);
        drain();

        // Random traffic, gap 0 gives back-to-back requests.
        for (int i = 0; i < 60; i++) begin
            p.waits = ($urandom_range(0, 9) == 0) ? TMO + 2 : int'($urandom_range(0, 3));
            p.rdata = $urandom;
            p.err   = ($urandom_range(0, 4) == 0);
            send(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom), p);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                req_valid = 1'b0;
                repeat (gap) @(negedge PCLK);
            end
        end
        drain();

        // Reset in the middle of an ACCESS wait: transfer dropped, no response.
        p.waits = 30; p.rdata = 32'h5A5A_5A5A; p.err = 1'b0;
        send(1'b1, 32'h4000_0040, 32'hCAFE_0001, 4'hF, 3'd5, p);
        req_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1 check_reset_vals("reset_mid_access");
        exp_q.delete();
        plan_q.delete();
        last_wdata = '0;
        @(negedge PCLK);
        check_reset_vals("reset_held");
        PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        p.waits = 1; p.rdata = 32'h7777_8888; p.err = 1'b0;
        send(1'b0, 32'hC000_0008, 32'h0, 4'h0, 3'd4, p);
        drain();
        p.waits = 0;
        send(1'b1, 32'h0000_0008, 32'h9999_0000, 4'h5, 3'd6, p);
        drain();
        repeat (3) @(negedge PCLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
